// File: rtl/fib_scheduler_pkg.sv
// Shared types for the Fibonacci core scheduler.
// Imported by the scheduler top.
package fib_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_CLR,
        WAIT_DONE,
        RESPOND
    } state_t;

endpackage

// File: rtl/fib_scheduler_if.sv
// Requester-side bundle: level requests in, one-cycle tagged responses out.
// master = client logic, slave = scheduler.
interface fib_scheduler_if #(
    parameter int NUM_REQ      = 4,
    parameter int INPUT_WIDTH  = 6,
    parameter int OUTPUT_WIDTH = 32
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ*INPUT_WIDTH-1:0] req_n;
    logic [NUM_REQ-1:0]             ack;
    logic                           resp_valid;
    logic [ID_W-1:0]                resp_id;
    logic [OUTPUT_WIDTH-1:0]        resp_result;
    logic                           resp_overflow;
    logic                           resp_timeout;

    modport master (
        output req, req_n,
        input  ack, resp_valid, resp_id,
        input  resp_result, resp_overflow, resp_timeout
    );

    modport slave (
        input  req, req_n,
        output ack, resp_valid, resp_id,
        output resp_result, resp_overflow, resp_timeout
    );

endinterface

// File: rtl/fib_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after rr_ptr,
// wrapping past NUM_REQ-1.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       grant_valid
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [2*NUM_REQ-1:0] dbl;
    int                   sum;

    always_comb begin
        grant_valid = |req;
        grant_id    = '0;
        dbl         = {req, req} >> rr_ptr;
        sum         = 0;
        // Scan downward so the lowest rotated offset wins last.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (dbl[k]) begin
                sum = int'(rr_ptr) + k;
                if (sum >= NUM_REQ) sum = sum - NUM_REQ;
                grant_id = ID_W'(sum);
            end
        end
    end

endmodule

// File: rtl/fib_scheduler.sv
// Round-robin sharing of one Fibonacci core among NUM_REQ requesters.
// Grants in IDLE, pulses core_go, waits for done or timeout, responds.
module fib_scheduler
    import fib_sched_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int INPUT_WIDTH  = 6,
    parameter int OUTPUT_WIDTH = 32,
    parameter int TIMEOUT      = 1023
) (
    input  logic                    clk,
    input  logic                    rst,
    fib_scheduler_if.slave          bus,
    output logic                    busy,
    output logic                    core_go,
    output logic [INPUT_WIDTH-1:0]  core_n,
    input  logic [OUTPUT_WIDTH-1:0] core_result,
    input  logic                    core_overflow,
    input  logic                    core_done
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int TW   = $clog2(TIMEOUT + 1);

    localparam logic [NUM_REQ-1:0] ONE     = NUM_REQ'(1);
    localparam logic [ID_W-1:0]    LAST_ID = ID_W'(NUM_REQ - 1);
    localparam logic [TW-1:0]      TMAX    = TW'(TIMEOUT);

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] id;
    logic [ID_W-1:0] grant_id;
    logic            grant_valid;
    logic [TW-1:0]   timer;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req         (bus.req),
        .rr_ptr      (rr_ptr),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state             <= IDLE;
            rr_ptr            <= '0;
            id                <= '0;
            timer             <= '0;
            busy              <= 1'b0;
            core_go           <= 1'b0;
            core_n            <= '0;
            bus.ack           <= '0;
            bus.resp_valid    <= 1'b0;
            bus.resp_id       <= '0;
            bus.resp_result   <= '0;
            bus.resp_overflow <= 1'b0;
            bus.resp_timeout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        id      <= grant_id;
                        core_n  <= bus.req_n[grant_id*INPUT_WIDTH +: INPUT_WIDTH];
                        core_go <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    core_go <= 1'b0;
                    state   <= WAIT_CLR;
                end
                WAIT_CLR: begin
                    // done may still be high from the previous job here
                    timer <= '0;
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (timer != TMAX) timer <= timer + 1'b1;
                    if (core_done || timer == TMAX) begin
                        state             <= RESPOND;
                        bus.resp_valid    <= 1'b1;
                        bus.ack           <= ONE << id;
                        bus.resp_id       <= id;
                        bus.resp_result   <= core_done ? core_result : '0;
                        bus.resp_overflow <= core_done & core_overflow;
                        bus.resp_timeout  <= ~core_done;
                    end
                end
                RESPOND: begin
                    bus.resp_valid <= 1'b0;
                    bus.ack        <= '0;
                    busy           <= 1'b0;
                    rr_ptr         <= (id == LAST_ID) ? '0 : id + 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
